// File: rtl/alu_ctrl_sequencer.sv
// Multi-cycle decode/sequence controller upstream of the 8-bit ALU.
// Optional: define ILLEGAL_TRAP_EN to halt on illegal instructions.
module alu_ctrl_sequencer #(
   parameter int INST_W      = 9,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              InstValid,
   input  logic [INST_W-1:0] Inst,
   output logic              InstReady,
   input  logic              Zero,
   input  logic              MemReady,
   output logic [1:0]        OP,
   output logic [1:0]        Function,
   output logic [2:0]        Immediate,
   output logic [2:0]        RegAddrA,
   output logic [2:0]        RegAddrB,
   output logic              RegWrite,
   output logic              MemRead,
   output logic              MemWrite,
   output logic              BranchTaken,
   output logic              Done,
   output logic              Halted,
   output logic              IllegalInst,
   output logic              MemError
);

   typedef enum logic [2:0] {
      S_IDLE, S_EXEC, S_MEM, S_WB, S_HENT, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_ALU, C_BEQ, C_SW, C_LW, C_MV, C_HALT, C_ILL
   } cls_t;

   localparam logic [3:0] CNT_LAST = 4'(MEM_TIMEOUT - 1);

   state_t            state, nstate;
   cls_t              cls;
   logic [INST_W-1:0] inst_q;
   logic [3:0]        cnt;
   logic [3:0]        opfn;
   logic              zero_q;
   logic              memfail;
   logic              illegal_q;
   logic              memerr_q;
   logic              is_alu;
   logic              mem_to;

   assign opfn = inst_q[8:5];

   always_comb begin
      is_alu = (opfn[3:2] == 2'b00 && !opfn[0]) ||
               opfn == 4'b0110 || opfn == 4'b1000 ||
               opfn == 4'b1001 || opfn == 4'b1100 ||
               opfn == 4'b1101;
      cls = C_ILL;
      unique case (1'b1)
         is_alu:                          cls = C_ALU;
         (opfn[3:2] == 2'b00 && opfn[0]): cls = C_BEQ;
         (opfn == 4'b0100):               cls = C_SW;
         (opfn == 4'b0101):               cls = C_LW;
         (opfn == 4'b0111):               cls = C_MV;
         (opfn == 4'b1011):               cls = C_HALT;
         default:                         cls = C_ILL;
      endcase
   end

   always_comb begin
      nstate = state;
      mem_to = 1'b0;
      case (state)
         S_IDLE: if (InstValid) nstate = S_EXEC;
         S_EXEC: begin
            case (cls)
               C_SW, C_LW: nstate = S_MEM;
               C_HALT:     nstate = S_HENT;
`ifdef ILLEGAL_TRAP_EN
               C_ILL:      nstate = S_HENT;
`endif
               default:    nstate = S_WB;
            endcase
         end
         S_MEM: begin
            // MemReady takes priority over a same-edge timeout
            if (MemReady) begin
               nstate = S_WB;
            end else if (cnt == CNT_LAST) begin
               nstate = S_WB;
               mem_to = 1'b1;
            end
         end
         S_WB:    nstate = S_IDLE;
         S_HENT:  nstate = S_HALT;
         S_HALT:  nstate = S_HALT;
         default: nstate = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= S_IDLE;
         inst_q    <= '0;
         cnt       <= '0;
         zero_q    <= 1'b0;
         memfail   <= 1'b0;
         illegal_q <= 1'b0;
         memerr_q  <= 1'b0;
      end else begin
         state <= nstate;
         if (state == S_IDLE && InstValid) begin
            inst_q  <= Inst;
            memfail <= 1'b0;
         end
         if (state == S_EXEC) begin
            zero_q <= Zero;
            cnt    <= '0;
            if (cls == C_ILL) illegal_q <= 1'b1;
         end
         if (state == S_MEM && !MemReady) cnt <= cnt + 4'd1;
         if (mem_to) begin
            memfail  <= 1'b1;
            memerr_q <= 1'b1;
         end
      end
   end

   always_comb begin
      InstReady   = (state == S_IDLE) && !Reset;
      OP          = inst_q[8:7];
      Function    = inst_q[6:5];
      Immediate   = inst_q[4:2];
      RegAddrA    = inst_q[4:2];
      RegAddrB    = {1'b0, inst_q[1:0]};
      MemRead     = (state == S_MEM) && (cls == C_LW);
      MemWrite    = (state == S_MEM) && (cls == C_SW);
      RegWrite    = 1'b0;
      BranchTaken = 1'b0;
      Done        = 1'b0;
      Halted      = (state == S_HENT) || (state == S_HALT);
      IllegalInst = illegal_q;
      MemError    = memerr_q;
      if (state == S_WB) begin
         Done        = 1'b1;
         RegWrite    = (cls == C_ALU) || (cls == C_MV) ||
                       (cls == C_LW && !memfail);
         BranchTaken = (cls == C_BEQ) && zero_q;
      end
      if (state == S_HENT) Done = 1'b1;
   end

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Directed-vector bench for alu_ctrl_sequencer.
// Define ILLEGAL_TRAP_EN to check the trapping build.
module tb_alu_ctrl_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       inst_valid;
   logic [8:0] inst;
   logic       inst_ready;
   logic       zero;
   logic       mem_ready;
   logic [1:0] op;
   logic [1:0] fn;
   logic [2:0] imm;
   logic [2:0] ra;
   logic [2:0] rb;
   logic       reg_write;
   logic       mem_read;
   logic       mem_write;
   logic       br_taken;
   logic       done;
   logic       halted;
   logic       illegal;
   logic       mem_err;

   int nvec = 0;
   int nerr = 0;

   alu_ctrl_sequencer dut (
      .Clk(clk), .Reset(rst),
      .InstValid(inst_valid), .Inst(inst),
      .InstReady(inst_ready), .Zero(zero),
      .MemReady(mem_ready), .OP(op),
      .Function(fn), .Immediate(imm),
      .RegAddrA(ra), .RegAddrB(rb),
      .RegWrite(reg_write), .MemRead(mem_read),
      .MemWrite(mem_write), .BranchTaken(br_taken),
      .Done(done), .Halted(halted),
      .IllegalInst(illegal), .MemError(mem_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] outvec();
      return 32'({inst_ready, reg_write, mem_read, mem_write,
                  br_taken, done, halted, illegal, mem_err,
                  op, fn, imm, ra, rb});
   endfunction

   task automatic do_reset();
      rst        = 1'b1;
      inst_valid = 1'b0;
      mem_ready  = 1'b0;
      zero       = 1'b0;
      inst       = '0;
      #1;
      chk("rst_outs", outvec(), 0);
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic issue(input logic [8:0] i);
      inst       = i;
      inst_valid = 1'b1;
      step();
      inst_valid = 1'b0;
   endtask

   initial begin
      int  n;
      logic seen;

      do_reset();
      chk("rdy_idle", 32'(inst_ready), 1);

      // add r3
      issue(9'b00_00_011_01);
      chk("add_op", 32'(op), 0);
      chk("add_fn", 32'(fn), 0);
      chk("add_ra", 32'(ra), 3);
      chk("add_rdy", 32'(inst_ready), 0);
      step();
      chk("add_rw", 32'(reg_write), 1);
      chk("add_done", 32'(done), 1);
      step();
      chk("add_rdy3", 32'(inst_ready), 1);
      chk("add_done3", 32'(done), 0);

      // beq taken
      issue(9'b00_01_001_10);
      zero = 1'b1;
      step();
      zero = 1'b0;
      chk("beq1_br", 32'(br_taken), 1);
      chk("beq1_done", 32'(done), 1);
      chk("beq1_rw", 32'(reg_write), 0);
      step();
      chk("beq1_br_off", 32'(br_taken), 0);

      // beq not taken
      issue(9'b00_01_001_10);
      step();
      chk("beq0_br", 32'(br_taken), 0);
      chk("beq0_done", 32'(done), 1);
      step();

      // LW with MemReady on third MEM cycle
      issue(9'b01_01_010_00);
      chk("lw_exec_rd", 32'(mem_read), 0);
      n = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (mem_read) n++;
         if (i == 2) mem_ready = 1'b1;
      end
      step();
      mem_ready = 1'b0;
      chk("lw_rd_cycles", 32'(n), 3);
      chk("lw_rd_wb", 32'(mem_read), 0);
      chk("lw_rw", 32'(reg_write), 1);
      chk("lw_ra", 32'(ra), 2);
      chk("lw_merr", 32'(mem_err), 0);
      chk("lw_done", 32'(done), 1);
      step();

      // SW with timeout
      issue(9'b01_00_001_00);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (mem_write) n++;
         else break;
      end
      chk("sw_wr_cycles", 32'(n), 15);
      chk("sw_merr", 32'(mem_err), 1);
      chk("sw_done", 32'(done), 1);
      chk("sw_rw", 32'(reg_write), 0);
      chk("sw_ill", 32'(illegal), 0);
      step();

      // illegal 11_11
      issue(9'b11_11_000_00);
      step();
      chk("ill_flag", 32'(illegal), 1);
      chk("ill_done", 32'(done), 1);
      chk("ill_rw", 32'(reg_write), 0);
`ifdef ILLEGAL_TRAP_EN
      chk("ill_halt", 32'(halted), 1);
      step();
      chk("ill_rdy", 32'(inst_ready), 0);
      chk("ill_halt2", 32'(halted), 1);
      chk("ill_done2", 32'(done), 0);
`else
      chk("ill_halt", 32'(halted), 0);
      step();
      chk("ill_rdy", 32'(inst_ready), 1);
`endif

      // HALT from fresh reset
      do_reset();
      issue(9'b10_11_000_00);
      step();
      chk("hlt_done", 32'(done), 1);
      chk("hlt_halt", 32'(halted), 1);
      step();
      chk("hlt_done2", 32'(done), 0);
      chk("hlt_rdy", 32'(inst_ready), 0);
      inst       = 9'b00_00_011_01;
      inst_valid = 1'b1;
      step();
      step();
      inst_valid = 1'b0;
      chk("hlt_ign_op", 32'(op), 2);
      chk("hlt_ign_halt", 32'(halted), 1);
      chk("hlt_ign_rw", 32'(reg_write), 0);

      // reset during LW MEM phase
      do_reset();
      issue(9'b01_01_010_00);
      step();
      step();
      chk("abort_rd_pre", 32'(mem_read), 1);
      rst = 1'b1;
      #1;
      chk("abort_rd", 32'(mem_read), 0);
      chk("abort_outs", outvec(), 0);
      step();
      rst = 1'b0;
      #1;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (done || reg_write || mem_read) seen = 1'b1;
         step();
      end
      chk("abort_quiet", 32'(seen), 0);
      chk("abort_rdy", 32'(inst_ready), 1);

      // mv after abort
      issue(9'b01_11_101_10);
      chk("mv_imm", 32'(imm), 5);
      chk("mv_rb", 32'(rb), 2);
      step();
      chk("mv_rw", 32'(reg_write), 1);
      chk("mv_done", 32'(done), 1);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_sequencer.md
Name: alu_ctrl_sequencer

Overview:
- Multi-cycle decoder/sequencer sitting upstream of the 8-bit ALU.
- Accepts 9-bit instructions from fetch via a valid/ready handshake and latches them.
- Drives the ALU's OP/Function/Immediate and the register-file addresses, then sequences the execute, memory and writeback phases.
- Consumes the ALU's Zero flag to resolve beq.

Parameters:
- INST_W, 9, instruction width; fields are fixed at the positions below.
- MEM_TIMEOUT, 15, max cycles in MEM waiting for MemReady before abort; 4-bit counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- InstValid  in  1  fetch presents an instruction.
- Inst  in  INST_W  instruction: [8:7] OP, [6:5] Function, [4:2] RegA/Immediate, [1:0] RegB.
- InstReady  out  1  sequencer can accept an instruction.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  data memory completed the access.
- OP  out  2  ALU OP, from the latched instruction.
- Function  out  2  ALU Function, from the latched instruction.
- Immediate  out  3  Inst[4:2] of the latched instruction.
- RegAddrA  out  3  Inst[4:2]; destination for ALU ops and LW.
- RegAddrB  out  3  {1'b0, Inst[1:0]}; destination for mv.
- RegWrite  out  1  register-file write enable.
- MemRead  out  1  LW request.
- MemWrite  out  1  SW request.
- BranchTaken  out  1  one-cycle pulse, beq taken.
- Done  out  1  one-cycle retire pulse.
- Halted  out  1  halt reached.
- IllegalInst  out  1  sticky flag.
- MemError  out  1  sticky flag, memory timeout.

Behaviour:
- Reset (async):
  - State goes to IDLE.
  - Instruction latch, MEM counter and sticky flags all clear to 0.
  - Every output is 0 while Reset is high, including InstReady.
  - Reset mid-operation aborts the instruction with no RegWrite, Done or memory strobe afterward.
- Decode classes, by {OP, Function}:
  - ALU: 00_x0 add, 01_10 slt, 10_00 orr, 10_01 sub, 11_00 sll, 11_01 srl.
  - BEQ: 00_x1.
  - MEM: 01_00 SW, 01_01 LW.
  - MV: 01_11.
  - HALT: 10_11.
  - ILLEGAL: 10_10, 11_10, 11_11.
- IDLE:
  - InstReady=1.
  - On InstValid && InstReady at a rising edge: latch Inst, go to EXEC.
  - Acceptance happens only in IDLE; InstValid in any other state is ignored.
- EXEC (1 cycle):
  - OP/Function/Immediate/RegAddr are stable from the latch; the ALU evaluates.
  - Zero is sampled into a register at the end of EXEC.
  - Next state: MEM for SW/LW, HALT for HALT, otherwise WB.
- MEM:
  - MemRead (LW) or MemWrite (SW) is held high while the counter increments.
  - MemReady=1 leaves for WB in the same edge; the strobe drops in WB.
  - If the counter reaches MEM_TIMEOUT with no MemReady: set MemError, go to WB with RegWrite suppressed.
  - MemReady and timeout on the same edge: MemReady wins.
- WB (1 cycle):
  - Done=1.
  - RegWrite=1 for ALU, MV, and LW without error.
  - BranchTaken=sampled Zero for BEQ, else 0.
  - ILLEGAL retires as a NOP and sets IllegalInst.
  - Next state: IDLE.
- HALT: Halted=1, InstReady=0; absorbing until Reset. Done pulses once on entry.
- Latency (accept edge = cycle 0):
  - ALU/MV/BEQ/ILLEGAL: Done in cycle 2, next accept in cycle 3.
  - MEM: Done one cycle after the MemReady edge.
  - Throughput is 1 instruction per 3 cycles minimum.
- Outputs are Moore functions of the state and latch registers; no combinational path from InstValid to InstReady.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an ILLEGAL instruction goes EXEC→HALT. IllegalInst and Halted assert, Done pulses once, no RegWrite.
- Undefined: ILLEGAL retires as a NOP through WB and the sequencer continues.

Test Plan:
- Reset, then Inst=9'b00_00_011_01 (add) with InstValid=1 at cycle 0 -> OP=00, Function=00, RegAddrA=3 in cycle 1; RegWrite=1 and Done=1 in cycle 2; InstReady=1 in cycle 3.
- beq 9'b00_01_001_10, Zero=1 during EXEC -> BranchTaken=1 for one cycle with Done. Repeat with Zero=0 -> BranchTaken=0, Done=1.
- LW 9'b01_01_010_00, MemReady rises after 3 MEM cycles -> MemRead high exactly 3 cycles; WB has RegWrite=1, RegAddrA=2, MemError=0.
- SW with MemReady held 0 -> MemWrite high 15 cycles; MemError=1; Done=1 with RegWrite=0; IllegalInst=0.
- 9'b11_11_000_00 -> without the macro: IllegalInst=1, Done, InstReady returns; with ILLEGAL_TRAP_EN: Halted=1, InstReady stays 0. Then HALT 9'b10_11_000_00 from a fresh reset -> Halted=1, later InstValid ignored.
- Assert Reset during MEM of an LW -> MemRead=0 immediately and no Done or RegWrite. After release, InstReady=1 and a mv 01_11_101_10 yields Immediate=5, RegAddrB=2, RegWrite=1.
